// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: system registers, timer, exception entry/ERET and MFC0/MTC0 access.
module cp0_exc_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] excepttype,
  input  logic [31:0] current_pc,
  input  logic        in_delayslot,
  input  logic [31:0] bad_addr,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        timer_int_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  localparam logic [AW-1:0] A_BADVADDR = AW'(8);
  localparam logic [AW-1:0] A_COUNT    = AW'(9);
  localparam logic [AW-1:0] A_COMPARE  = AW'(11);
  localparam logic [AW-1:0] A_STATUS   = AW'(12);
  localparam logic [AW-1:0] A_CAUSE    = AW'(13);
  localparam logic [AW-1:0] A_EPC      = AW'(14);
  localparam logic [AW-1:0] A_PRID     = AW'(15);

  localparam logic [DW-1:0] PRID_VAL     = 32'h0000_4220;
  localparam logic [DW-1:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [DW-1:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [DW-1:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [DW-1:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [DW-1:0] ERET_CODE    = 32'h0000_000E;

  logic [DW-1:0] status_q, status_d;
  logic [DW-1:0] cause_q, cause_d;
  logic [DW-1:0] epc_q, epc_d;
  logic [DW-1:0] badvaddr_q, badvaddr_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] compare_q, compare_d;
  logic          tick_q, tick_d;
  logic          timer_int_q, timer_int_d;

  logic          exc_valid_c;
  logic          bad_upd_c;
  logic [4:0]    exc_code_c;
  logic          any_exc_c;
  logic          is_eret_c;
  logic          mtc0_c;
  logic [DW-1:0] status_wr_c;
  logic [DW-1:0] cause_wr_c;

  assign any_exc_c   = (excepttype != '0);
  assign is_eret_c   = (excepttype == ERET_CODE);
  assign mtc0_c      = we_i && !any_exc_c;
  assign status_wr_c = (wdata_i & STATUS_WMASK) | (status_q & ~STATUS_WMASK);
  assign cause_wr_c  = (wdata_i & CAUSE_WMASK) | (cause_q & ~CAUSE_WMASK);

  // Translate the prioritized exception type into ExcCode and BadVAddr-update flag.
  always_comb begin
    exc_valid_c = 1'b1;
    bad_upd_c   = 1'b0;
    exc_code_c  = 5'd0;
    case (excepttype)
      32'h01: begin exc_code_c = 5'd0;  bad_upd_c = 1'b1; end
      32'h04: begin exc_code_c = 5'd4;  bad_upd_c = 1'b1; end
      32'h05: begin exc_code_c = 5'd5;  bad_upd_c = 1'b1; end
      32'h08: exc_code_c = 5'd8;
      32'h09: exc_code_c = 5'd9;
      32'h0a: exc_code_c = 5'd10;
      32'h0b: exc_code_c = 5'd11;
      32'h0c: exc_code_c = 5'd12;
      32'h0d: exc_code_c = 5'd13;
      32'h10: begin exc_code_c = 5'd1;  bad_upd_c = 1'b1; end
      32'h11, 32'h12: begin exc_code_c = 5'd2; bad_upd_c = 1'b1; end
      32'h13, 32'h14: begin exc_code_c = 5'd3; bad_upd_c = 1'b1; end
      default: exc_valid_c = 1'b0;
    endcase
  end

  // Next-state for all CP0 registers: timer, MTC0 writes, then exception/ERET overrides.
  always_comb begin
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    compare_d   = compare_q;
    tick_d      = ~tick_q;
    count_d     = tick_q ? count_q + DW'(1) : count_q;
    timer_int_d = timer_int_q;

    if ((count_q == compare_q) && (compare_q != '0)) begin
      timer_int_d = 1'b1;
    end

    if (mtc0_c) begin
      case (waddr_i)
        A_COUNT: begin
          count_d = wdata_i;
          tick_d  = 1'b0;
        end
        A_COMPARE: begin
          compare_d   = wdata_i;
          timer_int_d = 1'b0;
        end
        A_STATUS: status_d = status_wr_c;
        A_CAUSE:  cause_d  = cause_wr_c;
        A_EPC:    epc_d    = wdata_i;
        default: ;
      endcase
    end

    if (is_eret_c) begin
      status_d[1] = 1'b0;
    end else if (exc_valid_c) begin
      if (!status_q[1]) begin
        epc_d     = in_delayslot ? current_pc - DW'(4) : current_pc;
        cause_d[31] = in_delayslot;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code_c;
      if (bad_upd_c) begin
        badvaddr_d = bad_addr;
      end
    end

    cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q    <= STATUS_RST;
      cause_q     <= '0;
      epc_q       <= '0;
      badvaddr_q  <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      tick_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      tick_q      <= tick_d;
      timer_int_q <= timer_int_d;
    end
  end

  // MFC0 read mux with same-cycle MTC0 bypass.
  always_comb begin
    case (raddr_i)
      A_BADVADDR: rdata_o = badvaddr_q;
      A_COUNT:    rdata_o = count_q;
      A_COMPARE:  rdata_o = compare_q;
      A_STATUS:   rdata_o = status_q;
      A_CAUSE:    rdata_o = cause_q;
      A_EPC:      rdata_o = epc_q;
      A_PRID:     rdata_o = PRID_VAL;
      default:    rdata_o = '0;
    endcase
    if (we_i && (waddr_i == raddr_i)) begin
      case (waddr_i)
        A_COUNT:   rdata_o = wdata_i;
        A_COMPARE: rdata_o = wdata_i;
        A_STATUS:  rdata_o = status_wr_c;
        A_CAUSE:   rdata_o = cause_wr_c;
        A_EPC:     rdata_o = wdata_i;
        default: ;
      endcase
    end
  end

  // Flush/redirect is combinational so the pipeline redirects in the excepting cycle.
  assign flush_o     = resetn && any_exc_c;
  assign newpc_o     = !flush_o ? '0 : (is_eret_c ? epc_q : EXC_VECTOR);
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: vector table plus timer/reset/interrupt sequences.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        resetn;
  logic [31:0] excepttype;
  logic [31:0] current_pc;
  logic        in_delayslot;
  logic [31:0] bad_addr;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic        timer_int_o;

  int total = 0;
  int bad   = 0;

  cp0_exc_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .excepttype   (excepttype),
    .current_pc   (current_pc),
    .in_delayslot (in_delayslot),
    .bad_addr     (bad_addr),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .raddr_i      (raddr_i),
    .rdata_o      (rdata_o),
    .int_i        (int_i),
    .status_o     (status_o),
    .cause_o      (cause_o),
    .epc_o        (epc_o),
    .flush_o      (flush_o),
    .newpc_o      (newpc_o),
    .timer_int_o  (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exct;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] badaddr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] x_rdata;
    logic        x_flush;
    logic [31:0] x_newpc;
    logic [31:0] x_status;
    logic [31:0] x_cause;
    logic [31:0] x_epc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] exct, input logic [31:0] pc, input logic ds,
                              input logic [31:0] badaddr, input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic [4:0] raddr,
                              input logic [31:0] x_rdata, input logic x_flush,
                              input logic [31:0] x_newpc, input logic [31:0] x_status,
                              input logic [31:0] x_cause, input logic [31:0] x_epc);
    vec_t v;
    v.exct = exct; v.pc = pc; v.ds = ds; v.badaddr = badaddr;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
    v.x_rdata = x_rdata; v.x_flush = x_flush; v.x_newpc = x_newpc;
    v.x_status = x_status; v.x_cause = x_cause; v.x_epc = x_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    excepttype = '0; current_pc = '0; in_delayslot = 1'b0; bad_addr = '0;
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    step();
    we_i = 1'b0;
  endtask

  initial begin
    // exct, pc, ds, bad, we, waddr, wdata, raddr, x_rdata, x_flush, x_newpc, x_status, x_cause, x_epc
    vecs[0]  = mk(32'h08, 32'hBFC01000, 0, 0, 0, 0, 0, 15, 32'h00004220, 1, 32'hBFC00380, 32'h00400002, 32'h00000020, 32'hBFC01000);
    vecs[1]  = mk(32'h0e, 0, 0, 0, 0, 0, 0, 14, 32'hBFC01000, 1, 32'hBFC01000, 32'h00400000, 32'h00000020, 32'hBFC01000);
    vecs[2]  = mk(32'h04, 32'h80000010, 1, 32'h3, 0, 0, 0, 8, 32'h0, 1, 32'hBFC00380, 32'h00400002, 32'h80000010, 32'h8000000C);
    vecs[3]  = mk(32'h00, 0, 0, 0, 0, 0, 0, 8, 32'h3, 0, 32'h0, 32'h00400002, 32'h80000010, 32'h8000000C);
    vecs[4]  = mk(32'h0c, 32'h80000100, 0, 0, 0, 0, 0, 14, 32'h8000000C, 1, 32'hBFC00380, 32'h00400002, 32'h80000030, 32'h8000000C);
    vecs[5]  = mk(32'h0e, 0, 0, 0, 0, 0, 0, 13, 32'h80000030, 1, 32'h8000000C, 32'h00400000, 32'h80000030, 32'h8000000C);
    vecs[6]  = mk(32'h0a, 32'h80000200, 0, 0, 1, 12, 32'hFFFFFFFF, 12, 32'h0040FF03, 1, 32'hBFC00380, 32'h00400002, 32'h00000028, 32'h80000200);
    vecs[7]  = mk(32'h0e, 0, 0, 0, 0, 0, 0, 12, 32'h00400002, 1, 32'h80000200, 32'h00400000, 32'h00000028, 32'h80000200);
    vecs[8]  = mk(32'h00, 0, 0, 0, 1, 14, 32'h1234, 14, 32'h1234, 0, 32'h0, 32'h00400000, 32'h00000028, 32'h1234);
    vecs[9]  = mk(32'h00, 0, 0, 0, 1, 12, 32'hFFFFFFFF, 12, 32'h0040FF03, 0, 32'h0, 32'h0040FF03, 32'h00000028, 32'h1234);
    vecs[10] = mk(32'h00, 0, 0, 0, 1, 13, 32'hFFFFFFFF, 13, 32'h00000328, 0, 32'h0, 32'h0040FF03, 32'h00000328, 32'h1234);
    vecs[11] = mk(32'h00, 0, 0, 0, 1, 8, 32'hFFFF, 8, 32'h3, 0, 32'h0, 32'h0040FF03, 32'h00000328, 32'h1234);
    vecs[12] = mk(32'h00, 0, 0, 0, 1, 15, 32'hFFFF, 15, 32'h00004220, 0, 32'h0, 32'h0040FF03, 32'h00000328, 32'h1234);
    vecs[13] = mk(32'h20, 32'h80000300, 1, 32'h55, 0, 0, 0, 8, 32'h3, 1, 32'hBFC00380, 32'h0040FF03, 32'h00000328, 32'h1234);
    vecs[14] = mk(32'h10, 32'h80000400, 1, 32'hDEAD0000, 0, 0, 0, 8, 32'h3, 1, 32'hBFC00380, 32'h0040FF03, 32'h00000304, 32'h1234);
    vecs[15] = mk(32'h00, 0, 0, 0, 0, 0, 0, 8, 32'hDEAD0000, 0, 32'h0, 32'h0040FF03, 32'h00000304, 32'h1234);
    vecs[16] = mk(32'h0e, 0, 0, 0, 0, 0, 0, 10, 32'h0, 1, 32'h1234, 32'h0040FF01, 32'h00000304, 32'h1234);

    idle();
    int_i = '0;
    raddr_i = '0;

    // Reset asserted together with an exception and an MTC0 write.
    resetn = 1'b0;
    excepttype = 32'h08; current_pc = 32'h80001000;
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFFFFFF;
    #1;
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_newpc", newpc_o, 32'h0);
    step();
    step();
    check("rst_status", status_o, 32'h00400000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_timer", 32'(timer_int_o), 32'h0);
    idle();
    resetn = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      excepttype = vecs[i].exct; current_pc = vecs[i].pc; in_delayslot = vecs[i].ds;
      bad_addr = vecs[i].badaddr; we_i = vecs[i].we; waddr_i = vecs[i].waddr;
      wdata_i = vecs[i].wdata; raddr_i = vecs[i].raddr;
      #1;
      check($sformatf("v%0d_rdata", i), rdata_o, vecs[i].x_rdata);
      check($sformatf("v%0d_flush", i), 32'(flush_o), 32'(vecs[i].x_flush));
      check($sformatf("v%0d_newpc", i), newpc_o, vecs[i].x_newpc);
      step();
      idle();
      check($sformatf("v%0d_status", i), status_o, vecs[i].x_status);
      check($sformatf("v%0d_cause", i), cause_o, vecs[i].x_cause);
      check($sformatf("v%0d_epc", i), epc_o, vecs[i].x_epc);
    end

    // Interrupt lines sampled into Cause[15:10].
    int_i = 6'b000101;
    step();
    check("int_cause", 32'(cause_o[15:10]), 32'h05);
    int_i = '0;
    step();
    check("int_clear", 32'(cause_o[15:10]), 32'h0);

    // Timer: Count=0 then Compare=10; interrupt lands 21 edges after the Count write.
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd10);
    for (int k = 0; k < 19; k++) step();
    check("timer_early", 32'(timer_int_o), 32'h0);
    raddr_i = 5'd9;
    #1;
    check("count_at10", rdata_o, 32'd10);
    step();
    check("timer_set", 32'(timer_int_o), 32'h1);
    step();
    check("cause15", 32'(cause_o[15]), 32'h1);
    for (int k = 0; k < 5; k++) step();
    check("timer_hold", 32'(timer_int_o), 32'h1);
    mtc0(5'd11, 32'd100);
    check("timer_clr", 32'(timer_int_o), 32'h0);

    // Count wraps at 0xFFFFFFFF with no side effect.
    mtc0(5'd9, 32'hFFFFFFFF);
    raddr_i = 5'd9;
    #1;
    check("count_max", rdata_o, 32'hFFFFFFFF);
    step();
    step();
    check("count_wrap", rdata_o, 32'h0);
    check("wrap_timer", 32'(timer_int_o), 32'h0);

    // Mid-run reset clears everything again.
    resetn = 1'b0;
    excepttype = 32'h04; bad_addr = 32'h77;
    step();
    idle();
    resetn = 1'b1;
    raddr_i = 5'd8;
    #1;
    check("rst2_bad", rdata_o, 32'h0);
    check("rst2_status", status_o, 32'h00400000);
    check("rst2_epc", epc_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
